// File: rtl/ex_lsu_if.sv
// Data-SRAM request/grant bus between the EX-stage LSU and the memory system.
interface ex_lsu_if #(
    parameter int ADDR_W = 64
);
    logic              data_sram_en;
    logic [7:0]        data_sram_we;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [63:0]       data_sram_wdata;
    logic              data_sram_gnt;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_gnt
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_gnt
    );
endinterface

// File: rtl/ex_lsu.sv
// EX-stage load/store request unit: builds an aligned 64-bit data-SRAM
// request, flags misaligned accesses and stalls EX until the bus grants.
module ex_lsu #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              req_valid,
    input  logic [6:0]        lsu_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       store_data,
    ex_lsu_if.master          sram,
    output logic [7:0]        data_ram_sel,
    output logic              stallreq_lsu,
    output logic              exc_valid,
    output logic [3:0]        exc_code
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e state_q, state_d;

    logic              ram_en, ram_we, sz_b, sz_h, sz_w, sz_d;
    logic [2:0]        a;
    logic              mem_op, misalign;
    logic [7:0]        sel_now;
    logic [ADDR_W-1:0] addr_now;
    logic [63:0]       wdata_now;
    logic              capture;

    logic [7:0]        sel_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;

    // Signedness bit only matters for load extension in MEM.
    logic              unused_sign;
    assign unused_sign = lsu_op[0];

    assign ram_en = lsu_op[6];
    assign ram_we = lsu_op[5];
    assign sz_b   = lsu_op[4];
    assign sz_h   = lsu_op[3];
    assign sz_w   = lsu_op[2];
    assign sz_d   = lsu_op[1];
    assign a      = addr[2:0];

    assign mem_op    = req_valid & ram_en & ~flush;
    assign misalign  = (sz_h & a[0]) | (sz_w & (a[1:0] != 2'b00)) | (sz_d & (a != 3'b000));
    assign addr_now  = {addr[ADDR_W-1:3], 3'b000};
    assign wdata_now = store_data << {a, 3'b000};

    // Byte-lane mask for the current access size and offset.
    always_comb begin
        sel_now = '0;
        if (sz_d)      sel_now = 8'hFF;
        else if (sz_w) sel_now = 8'h0F << a;
        else if (sz_h) sel_now = 8'h03 << a;
        else if (sz_b) sel_now = 8'h01 << a;
    end

    // Next-state and bus outputs; WAIT replays the captured request.
    always_comb begin
        state_d              = state_q;
        sram.data_sram_en    = 1'b0;
        sram.data_sram_we    = '0;
        sram.data_sram_addr  = '0;
        sram.data_sram_wdata = '0;
        data_ram_sel         = '0;
        stallreq_lsu         = 1'b0;
        exc_valid            = 1'b0;
        exc_code             = '0;
        capture              = 1'b0;
        if (!rst_n || flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        data_ram_sel         = sel_now;
                        sram.data_sram_we    = ram_we ? sel_now : 8'h00;
                        sram.data_sram_addr  = addr_now;
                        sram.data_sram_wdata = wdata_now;
                        if (misalign) begin
                            exc_valid = 1'b1;
                            exc_code  = ram_we ? 4'd6 : 4'd4;
                        end else begin
                            sram.data_sram_en = 1'b1;
                            if (!sram.data_sram_gnt) begin
                                stallreq_lsu = 1'b1;
                                capture      = 1'b1;
                                state_d      = S_WAIT;
                            end else if (ex_stall) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    sram.data_sram_en    = 1'b1;
                    data_ram_sel         = sel_q;
                    sram.data_sram_we    = we_q;
                    sram.data_sram_addr  = addr_q;
                    sram.data_sram_wdata = wdata_q;
                    if (sram.data_sram_gnt) state_d = ex_stall ? S_DONE : S_IDLE;
                    else                    stallreq_lsu = 1'b1;
                end
                S_DONE: begin
                    if (mem_op) begin
                        data_ram_sel         = sel_now;
                        sram.data_sram_we    = ram_we ? sel_now : 8'h00;
                        sram.data_sram_addr  = addr_now;
                        sram.data_sram_wdata = wdata_now;
                    end
                    if (!ex_stall) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Hold the ungranted request so it stays stable while waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            sel_q   <= sel_now;
            we_q    <= ram_we ? sel_now : 8'h00;
            addr_q  <= addr_now;
            wdata_q <= wdata_now;
        end
    end
endmodule

// File: tb/tb_ex_lsu.sv
// Directed bench for ex_lsu: single-cycle vector table plus multi-cycle
// handshake sequences (slow grant, grant under stall, flush, reset).
module tb_ex_lsu;
    localparam logic [6:0] LB = 7'h50, LH = 7'h48, LW = 7'h44, LD = 7'h42;
    localparam logic [6:0] SB = 7'h70, SH = 7'h68, SW = 7'h64, SD = 7'h62;

    logic        clk = 1'b0;
    logic        rst_n, flush, ex_stall, req_valid;
    logic [6:0]  lsu_op;
    logic [63:0] addr, store_data;
    logic [7:0]  data_ram_sel;
    logic        stallreq_lsu, exc_valid;
    logic [3:0]  exc_code;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    ex_lsu_if #(.ADDR_W(64)) bus ();

    ex_lsu #(.ADDR_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .req_valid    (req_valid),
        .lsu_op       (lsu_op),
        .addr         (addr),
        .store_data   (store_data),
        .sram         (bus),
        .data_ram_sel (data_ram_sel),
        .stallreq_lsu (stallreq_lsu),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rv;
        logic [6:0]  op;
        logic [63:0] a;
        logic [63:0] sd;
        logic        fl;
        logic        en;
        logic [7:0]  we;
        logic [63:0] sa;
        logic [63:0] wd;
        logic [7:0]  sel;
        logic        stall;
        logic        exv;
        logic [3:0]  code;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic chk_all(input string nm, input logic en, input logic [7:0] we,
                           input logic [63:0] sa, input logic [63:0] wd, input logic [7:0] sel,
                           input logic stall, input logic exv, input logic [3:0] code);
        chk({nm, ".en"},    64'(bus.data_sram_en),    64'(en));
        chk({nm, ".we"},    64'(bus.data_sram_we),    64'(we));
        chk({nm, ".addr"},  bus.data_sram_addr,       sa);
        chk({nm, ".wdata"}, bus.data_sram_wdata,      wd);
        chk({nm, ".sel"},   64'(data_ram_sel),        64'(sel));
        chk({nm, ".stall"}, 64'(stallreq_lsu),        64'(stall));
        chk({nm, ".exc"},   64'(exc_valid),           64'(exv));
        chk({nm, ".code"},  64'(exc_code),            64'(code));
    endtask

    task automatic drive(input logic rv, input logic [6:0] op, input logic [63:0] a,
                         input logic [63:0] sd, input logic gnt, input logic stl, input logic fl);
        req_valid = rv; lsu_op = op; addr = a; store_data = sd;
        bus.data_sram_gnt = gnt; ex_stall = stl; flush = fl;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    int unsigned cnt;

    initial begin
        //           rv op  addr                   store_data              fl en we     sram_addr              wdata                   sel    st exv code
        vt[0]  = '{1, SW, 64'h8000_0004, 64'h1122_3344,          0, 1, 8'hF0, 64'h8000_0000, 64'h1122_3344_0000_0000, 8'hF0, 0, 0, 4'd0};
        vt[1]  = '{1, LH, 64'h1003,      64'h55,                 0, 0, 8'h00, 64'h1000,      64'h5500_0000,           8'h18, 0, 1, 4'd4};
        vt[2]  = '{1, SD, 64'h1004,      64'h0102_0304_0506_0708, 0, 0, 8'hFF, 64'h1000,     64'h0506_0708_0000_0000, 8'hFF, 0, 1, 4'd6};
        vt[3]  = '{1, LB, 64'h2007,      64'h0,                  0, 1, 8'h00, 64'h2000,      64'h0,                   8'h80, 0, 0, 4'd0};
        vt[4]  = '{0, SW, 64'h8000_0004, 64'h1122_3344,          0, 0, 8'h00, 64'h0,         64'h0,                   8'h00, 0, 0, 4'd0};
        vt[5]  = '{1, SH, 64'h3006,      64'hBEEF,               0, 1, 8'hC0, 64'h3000,      64'hBEEF_0000_0000_0000, 8'hC0, 0, 0, 4'd0};
        vt[6]  = '{1, LD, 64'h10,        64'hFFFF,               0, 1, 8'h00, 64'h10,        64'hFFFF,                8'hFF, 0, 0, 4'd0};
        vt[7]  = '{1, SW, 64'h2,         64'h1,                  0, 0, 8'h3C, 64'h0,         64'h1_0000,              8'h3C, 0, 1, 4'd6};
        vt[8]  = '{1, SW, 64'h8,         64'h7,                  1, 0, 8'h00, 64'h0,         64'h0,                   8'h00, 0, 0, 4'd0};
        vt[9]  = '{1, 7'h08, 64'h4,      64'h9,                  0, 0, 8'h00, 64'h0,         64'h0,                   8'h00, 0, 0, 4'd0};
        vt[10] = '{1, LW, 64'hC,         64'h1234_5678,          0, 1, 8'h00, 64'h8,         64'h1234_5678_0000_0000, 8'hF0, 0, 0, 4'd0};
        vt[11] = '{1, SB, 64'h5,         64'h12,                 0, 1, 8'h20, 64'h0,         64'h0000_1200_0000_0000, 8'h20, 0, 0, 4'd0};
        vt[12] = '{1, LH, 64'h2,         64'h0,                  0, 1, 8'h00, 64'h0,         64'h0,                   8'h0C, 0, 0, 4'd0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 7'h0, 64'h0, 64'h0, 0, 0, 0);
        adv(); adv();
        @(negedge clk);
        chk_all("reset", 0, 8'h00, 64'h0, 64'h0, 8'h00, 0, 0, 4'd0);
        adv();
        rst_n = 1'b1;

        // Single-cycle vectors, immediate grant, no downstream stall
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rv, vt[i].op, vt[i].a, vt[i].sd, 1, 0, vt[i].fl);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vt[i].en, vt[i].we, vt[i].sa, vt[i].wd,
                    vt[i].sel, vt[i].stall, vt[i].exv, vt[i].code);
            adv();
        end

        // LB from a slow bus: three ungranted cycles, request held stable
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, LB, (i == 0) ? 64'h2007 : 64'h3001, 64'h0, (i == 3), 0, 0);
            @(negedge clk);
            chk($sformatf("slow%0d.en", i), 64'(bus.data_sram_en), 64'd1);
            chk($sformatf("slow%0d.sel", i), 64'(data_ram_sel), 64'h80);
            chk($sformatf("slow%0d.addr", i), bus.data_sram_addr, 64'h2000);
            if (stallreq_lsu) cnt++;
            adv();
        end
        chk("slow.stall_cycles", 64'(cnt), 64'd3);
        drive(0, 7'h0, 64'h0, 64'h0, 0, 0, 0);
        @(negedge clk);
        chk("slow.idle_en", 64'(bus.data_sram_en), 64'd0);
        chk("slow.idle_stall", 64'(stallreq_lsu), 64'd0);
        adv();

        // SB granted while EX is held for two more cycles: one request only
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, SB, 64'h4001, 64'hAB, 1, (i < 3), 0);
            @(negedge clk);
            if (i == 0) begin
                chk("dstall.we", 64'(bus.data_sram_we), 64'h02);
                chk("dstall.wdata", bus.data_sram_wdata, 64'hAB00);
            end
            chk($sformatf("dstall%0d.stall", i), 64'(stallreq_lsu), 64'd0);
            if (bus.data_sram_en) cnt++;
            adv();
        end
        chk("dstall.en_cycles", 64'(cnt), 64'd1);
        drive(1, LB, 64'h4000, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk("dstall.next_en", 64'(bus.data_sram_en), 64'd1);
        adv();

        // Flush the cycle after an ungranted request; late grant ignored
        drive(1, SW, 64'h5008, 64'h99, 0, 0, 0);
        @(negedge clk);
        chk_all("flushw.req", 1, 8'h0F, 64'h5008, 64'h99, 8'h0F, 1, 0, 4'd0);
        adv();
        drive(1, SW, 64'h5008, 64'h99, 1, 0, 1);
        @(negedge clk);
        chk_all("flushw.flush", 0, 8'h00, 64'h0, 64'h0, 8'h00, 0, 0, 4'd0);
        adv();
        drive(1, LW, 64'h600C, 64'h0, 0, 0, 0);
        @(negedge clk);
        chk_all("flushw.new", 1, 8'h00, 64'h6008, 64'h0, 8'hF0, 1, 0, 4'd0);
        adv();
        drive(1, LW, 64'h600C, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk("flushw.gnt_addr", bus.data_sram_addr, 64'h6008);
        chk("flushw.gnt_stall", 64'(stallreq_lsu), 64'd0);
        adv();

        // Reset while waiting for grant
        drive(1, LD, 64'h7040, 64'h0, 0, 0, 0);
        @(negedge clk);
        chk("rstw.stall", 64'(stallreq_lsu), 64'd1);
        adv();
        rst_n = 1'b0;
        @(negedge clk);
        chk_all("rstw.in_reset", 0, 8'h00, 64'h0, 64'h0, 8'h00, 0, 0, 4'd0);
        adv();
        rst_n = 1'b1;
        drive(0, 7'h0, 64'h0, 64'h0, 0, 0, 0);
        @(negedge clk);
        chk("rstw.after_en", 64'(bus.data_sram_en), 64'd0);
        adv();
        drive(1, LB, 64'h7101, 64'h0, 1, 0, 0);
        @(negedge clk);
        chk_all("rstw.idle", 1, 8'h00, 64'h7100, 64'h0, 8'h02, 0, 0, 4'd0);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
